// File: rtl/scanner_pkg.sv
// Shared types and constants for the truth-table scanner: FSM state encoding,
// default code-space size and the expected table of the 4'b1010 comparator.
package scanner_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} scan_state_t;

  localparam int N_IN_DEFAULT = 4;
  localparam int N_CODES      = 2**N_IN_DEFAULT;

  // Q=1 only for code 4'b1010, so bit 10 alone is set.
  localparam logic [N_CODES-1:0] EXPECTED_CMP_1010 = 16'h0400;

endpackage : scanner_pkg

// File: rtl/scan_settle_timer.sv
// Settle-window down-counter: load SETTLE_CYCLES-1, decrement on request,
// report when it has reached zero.
module scan_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments and is cleared by the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= W'(SETTLE_CYCLES - 1);
    else if (dec)  cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule : scan_settle_timer

// File: rtl/truth_table_scanner.sv
// Walks every input code through a combinational comparator, samples Q after a
// settle window, and builds/compares the resulting truth table.
module truth_table_scanner
  import scanner_pkg::*;
#(
  parameter int                   N_IN          = 4,
  parameter int                   SETTLE_CYCLES = 1,
  parameter logic [2**N_IN-1:0]   EXPECTED      = EXPECTED_CMP_1010
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 q_i,
  output logic [N_IN-1:0]      code_o,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_o,
  output logic [N_IN:0]        ones_o,
  output logic                 match_o
);

  scan_state_t          state_q, state_d;
  logic [N_IN-1:0]      code_d;
  logic [2**N_IN-1:0]   table_d;
  logic [N_IN:0]        ones_d;
  logic                 match_d, busy_d, done_d;
  logic                 load, dec, zero;

  scan_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .dec  (dec),
    .zero (zero)
  );

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    code_d  = code_o;
    table_d = table_o;
    ones_d  = ones_o;
    match_d = match_o;
    busy_d  = busy;
    done_d  = 1'b0;
    load    = 1'b0;
    dec     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          table_d = '0;
          ones_d  = '0;
          match_d = 1'b0;
          code_d  = '0;
          busy_d  = 1'b1;
          load    = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (zero) state_d = SAMPLE;
        else      dec     = 1'b1;
      end
      SAMPLE: begin
        table_d[code_o] = q_i;
        ones_d          = ones_o + {{N_IN{1'b0}}, q_i};
        if (code_o == {N_IN{1'b1}}) begin
          state_d = DONE;
        end else begin
          code_d  = code_o + N_IN'(1);
          load    = 1'b1;
          state_d = SETTLE;
        end
      end
      DONE: begin
        // done and match leave this state together, one edge after the last sample.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        match_d = (table_o == EXPECTED);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_o  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      table_o <= '0;
      ones_o  <= '0;
      match_o <= 1'b0;
    end else begin
      state_q <= state_d;
      code_o  <= code_d;
      busy    <= busy_d;
      done    <= done_d;
      table_o <= table_d;
      ones_o  <= ones_d;
      match_o <= match_d;
    end
  end

endmodule : truth_table_scanner
